led_heartbeat: RTL and testbench

Parametrised multi-channel LED indicator controller; the successor to the single fixed 1 s blinker in the SoC top level. It drives CH LEDs from one shared, runtime-programmable time base. Each channel is independently set to off, on, blink or double-flash, and a restart input phase-aligns all channels. It sits in the top level beside the PLL and SoC and runs on the board clock.

---
 rtl/led_heartbeat.sv | 94 +++++++++
 tb/tb_led_heartbeat.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/led_heartbeat.sv
// Multi-channel LED indicator: shared programmable time base, per-channel off/on/blink/double-flash.
// Optional global PWM dimming when LED_DIM_EN is defined (adds the dim port).
module led_heartbeat #(
    parameter int unsigned CH       = 4,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned DEF_HALF = 50000000
) (
    input  logic               sysclk,
    input  logic               rst_n,
    input  logic [CNT_W-1:0]   half_period,
    input  logic [2*CH-1:0]    mode,
    input  logic               restart,
`ifdef LED_DIM_EN
    input  logic [7:0]         dim,
`endif
    output logic [CH-1:0]      led,
    output logic               tick
);

    localparam int unsigned STEP_W = 3;

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [STEP_W-1:0] step;
    logic [STEP_W-1:0] step_nxt;
    logic              tick_nxt;
    logic [CH-1:0]     led_nxt;
    logic [CNT_W-1:0]  period;
    logic              wrap;

    // Zero on the input selects the built-in default period
    assign period = (half_period == '0) ? CNT_W'(DEF_HALF) : half_period;
    assign wrap   = (cnt >= (period - CNT_W'(1)));

`ifdef LED_DIM_EN
    logic [7:0] pwm_cnt;
    logic       gate;

    assign gate = (dim == 8'hFF) | (pwm_cnt < dim);

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) pwm_cnt <= '0;
        else        pwm_cnt <= pwm_cnt + 8'(1);
    end
`endif

    // State register
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            step <= '0;
            tick <= 1'b0;
            led  <= '0;
        end else begin
            cnt  <= cnt_nxt;
            step <= step_nxt;
            tick <= tick_nxt;
            led  <= led_nxt;
        end
    end

    // Time base and step sequencer; restart wins over a coincident wrap
    always_comb begin
        cnt_nxt  = cnt + CNT_W'(1);
        step_nxt = step;
        tick_nxt = 1'b0;
        if (restart) begin
            cnt_nxt  = '0;
            step_nxt = '0;
        end else if (wrap) begin
            cnt_nxt  = '0;
            step_nxt = step + STEP_W'(1);
            tick_nxt = 1'b1;
        end
    end

    // LED pattern decode from the next-state step so blink edges line up with tick
    always_comb begin
        led_nxt = '0;
        for (int i = 0; i < int'(CH); i++) begin
            unique case (mode[2*i +: 2])
                2'b00: led_nxt[i] = 1'b0;
                2'b01: led_nxt[i] = 1'b1;
                2'b10: led_nxt[i] = step_nxt[0];
                2'b11: led_nxt[i] = (step_nxt == STEP_W'(1)) || (step_nxt == STEP_W'(3));
                default: led_nxt[i] = 1'b0;
            endcase
        end
`ifdef LED_DIM_EN
        led_nxt = led_nxt & {CH{gate}};
`endif
    end

endmodule

// File: tb/tb_led_heartbeat.sv
// Scoreboard bench for led_heartbeat: stimulus queues per-edge expectations, monitor pops and compares.
// Dimming checks run only when LED_DIM_EN is defined.
module tb_led_heartbeat;

    localparam int unsigned CH    = 4;
    localparam int unsigned CNT_W = 32;

    logic             sysclk = 1'b0;
    logic             rst_n;
    logic [CNT_W-1:0] half_period;
    logic [2*CH-1:0]  mode;
    logic             restart;
    logic [CH-1:0]    led;
    logic             tick;
`ifdef LED_DIM_EN
    logic [7:0]       dim;
`endif

    int checks   = 0;
    int failures = 0;
    int tid      = 0;

    typedef struct {
        logic [CH-1:0] led;
        logic          tick;
        int            tid;
        int            k;
    } exp_t;

    exp_t q[$];

    always #5 sysclk = ~sysclk;

    led_heartbeat #(.CH(CH), .CNT_W(CNT_W), .DEF_HALF(10)) dut (
        .sysclk      (sysclk),
        .rst_n       (rst_n),
        .half_period (half_period),
        .mode        (mode),
        .restart     (restart),
`ifdef LED_DIM_EN
        .dim         (dim),
`endif
        .led         (led),
        .tick        (tick)
    );

    // Monitor: one expectation per active edge, sampled 1 time unit after it
    initial begin
        exp_t e;
        forever begin
            @(posedge sysclk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (led !== e.led || tick !== e.tick) begin
                    failures++;
                    $display("FAIL test%0d cyc%0d: led=%h tick=%b required led=%h tick=%b",
                             e.tid, e.k, led, tick, e.led, e.tick);
                end
            end
        end
    end

    task automatic cyc(input logic [CH-1:0] el, input logic et, input int k);
        exp_t e;
        e.led = el; e.tick = et; e.tid = tid; e.k = k;
        q.push_back(e);
        @(posedge sysclk);
        @(negedge sysclk);
    endtask

    task automatic do_restart(input logic [CH-1:0] el);
        restart = 1'b1;
        cyc(el, 1'b0, 0);
        restart = 1'b0;
    endtask

`ifdef LED_DIM_EN
    task automatic dim_check(input logic [7:0] d, input int want);
        int hi;
        dim = d;
        @(negedge sysclk);
        @(negedge sysclk);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            if (led === 4'hF) hi++;
            @(negedge sysclk);
        end
        checks++;
        if (hi != want) begin
            failures++;
            $display("FAIL dim%0d: high_cycles=%0d required=%0d", d, hi, want);
        end
    endtask
`endif

    initial begin
        logic [0:15] dfpat;
        rst_n       = 1'b0;
        half_period = CNT_W'(4);
        mode        = 8'hAA;
        restart     = 1'b0;
`ifdef LED_DIM_EN
        dim         = 8'hFF;
`endif
        @(negedge sysclk);

        // Reset state
        tid = 0;
        cyc(4'h0, 1'b0, 0);
        cyc(4'h0, 1'b0, 1);
        rst_n = 1'b1;

        // P=4 blink on all channels from reset release
        tid = 1;
        for (int k = 1; k <= 12; k++)
            cyc(((k / 4) % 2 == 1) ? 4'hF : 4'h0, (k % 4) == 0, k);

        // P=1: tick every cycle, blink toggles every cycle including step 7->0
        tid = 2;
        half_period = CNT_W'(1);
        do_restart(4'h0);
        for (int k = 1; k <= 9; k++)
            cyc((k % 2 == 1) ? 4'hF : 4'h0, 1'b1, k);

        // half_period=0 selects DEF_HALF (10 here); channel 0 blink only
        tid = 3;
        half_period = '0;
        mode = 8'b00_00_00_10;
        do_restart(4'h0);
        for (int k = 1; k <= 10; k++)
            cyc((k == 10) ? 4'h1 : 4'h0, k == 10, k);

        // Double-flash, P=2: two 16-cycle pattern periods
        tid = 4;
        half_period = CNT_W'(2);
        mode = 8'b00_00_00_11;
        dfpat = 16'b0011_0011_0000_0000;
        do_restart(4'h0);
        for (int k = 1; k <= 32; k++)
            cyc({3'b000, dfpat[k % 16]}, (k % 2) == 0, k);

        // Period lowered 100 -> 3 with cnt at 50: immediate wrap, then every 3
        tid = 5;
        half_period = CNT_W'(100);
        mode = 8'b00_00_00_01;
        do_restart(4'h1);
        for (int k = 1; k <= 50; k++)
            cyc(4'h1, 1'b0, k);
        half_period = CNT_W'(3);
        for (int k = 1; k <= 10; k++)
            cyc(4'h1, (k % 3) == 1, 100 + k);

        // Restart coincident with a wrap while flashing
        tid = 6;
        half_period = CNT_W'(4);
        mode = 8'hFF;
        do_restart(4'h0);
        for (int k = 1; k <= 7; k++)
            cyc((k >= 4) ? 4'hF : 4'h0, k == 4, k);
        do_restart(4'h0);
        for (int k = 1; k <= 4; k++)
            cyc((k == 4) ? 4'hF : 4'h0, k == 4, 10 + k);

        // Reset dropped mid-flash clears outputs without waiting for an edge
        tid = 7;
        rst_n = 1'b0;
        #1;
        checks++;
        if (led !== 4'h0 || tick !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: led=%h tick=%b required led=0 tick=0", led, tick);
        end
        @(negedge sysclk);
        cyc(4'h0, 1'b0, 0);
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++)
            cyc((k >= 4 && k <= 7) ? 4'hF : 4'h0, (k % 4) == 0, k);

`ifdef LED_DIM_EN
        tid = 8;
        mode = 8'h55;
        dim_check(8'd64, 64);
        dim_check(8'hFF, 256);
        dim_check(8'd0, 0);
`endif

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(negedge sysclk);
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: pending=%0d required=0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
